dmem_arbiter: RTL

Two-requester arbiter sharing the single-port synchronous data memory (`dmem`) between the processor's memory stage (port 0) and a secondary master such as a loader or debug engine (port 1). It sits between the requesters and the `dmem` instance and drives the memory's address, data and write enable from the current owner. Arbitration is round-robin with a bounded hold counter, so neither side can starve the other under contention. Read data returns one cycle after the accepted transfer, matching the `dmem` registered read.

---
 rtl/dmem_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port synchronous data memory between the
// processor memory stage (port 0) and a secondary master (port 1).
// Ownership is round-robin with a bounded hold counter so that neither port
// can starve the other. Grants are combinational from the registered owner;
// read-valid flags are registered to line up with the dmem registered read.
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] dmem_address,
  output logic [DATA_W-1:0] dmem_data,
  output logic              dmem_wren,
  input  logic [DATA_W-1:0] dmem_q
);

  localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  // last_q encoding: 1'b0 = port 0 served most recently, 1'b1 = port 1
  owner_e            owner_q, owner_d;
  logic              last_q, last_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              p0_rvalid_q, p0_rvalid_d;
  logic              p1_rvalid_q, p1_rvalid_d;

  logic              xfer0_s;
  logic              xfer1_s;

  // A grant is only ever offered to the registered owner while it requests;
  // a grant always coincides with a transfer.
  always_comb begin
    xfer0_s = (owner_q == OWN_P0) && p0_req;
    xfer1_s = (owner_q == OWN_P1) && p1_req;
  end

  assign p0_gnt    = xfer0_s;
  assign p1_gnt    = xfer1_s;
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign rdata     = dmem_q;

  // Steer the transferring port onto the memory bus; park the bus at zero otherwise.
  always_comb begin
    dmem_address = {ADDR_W{1'b0}};
    dmem_data    = {DATA_W{1'b0}};
    dmem_wren    = 1'b0;
    if (xfer0_s) begin
      dmem_address = p0_addr;
      dmem_data    = p0_wdata;
      dmem_wren    = p0_we;
    end else if (xfer1_s) begin
      dmem_address = p1_addr;
      dmem_data    = p1_wdata;
      dmem_wren    = p1_we;
    end else begin
      dmem_address = {ADDR_W{1'b0}};
      dmem_data    = {DATA_W{1'b0}};
      dmem_wren    = 1'b0;
    end
  end

  // Next owner, most-recent server, hold count and read-valid flags.
  always_comb begin
    owner_d     = owner_q;
    last_d      = last_q;
    hold_d      = hold_q;
    p0_rvalid_d = xfer0_s && !p0_we;
    p1_rvalid_d = xfer1_s && !p1_we;

    case (owner_q)
      OWN_NONE: begin
        if (p0_req && p1_req) begin
          owner_d = last_q ? OWN_P0 : OWN_P1;
        end else if (p0_req) begin
          owner_d = OWN_P0;
        end else if (p1_req) begin
          owner_d = OWN_P1;
        end else begin
          owner_d = OWN_NONE;
        end
      end
      OWN_P0: begin
        if (!p0_req) begin
          owner_d = p1_req ? OWN_P1 : OWN_NONE;
        end else if ((hold_q == HOLD_LAST) && p1_req) begin
          owner_d = OWN_P1;
        end else begin
          owner_d = OWN_P0;
        end
      end
      OWN_P1: begin
        if (!p1_req) begin
          owner_d = p0_req ? OWN_P0 : OWN_NONE;
        end else if ((hold_q == HOLD_LAST) && p0_req) begin
          owner_d = OWN_P0;
        end else begin
          owner_d = OWN_P1;
        end
      end
      default: begin
        owner_d = OWN_NONE;
      end
    endcase

    if (xfer0_s) begin
      last_d = 1'b0;
    end else if (xfer1_s) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end

    // The count saturates at the switch threshold so that an owner that has
    // streamed alone for a long time yields as soon as the other side asks.
    if (owner_d != owner_q) begin
      hold_d = {HOLD_W{1'b0}};
    end else if ((xfer0_s || xfer1_s) && (hold_q != HOLD_LAST)) begin
      hold_d = hold_q + HOLD_W'(1);
    end else begin
      hold_d = hold_q;
    end
  end

  // Arbitration state and read-valid registers; reset drops any pending rvalid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q     <= OWN_NONE;
      last_q      <= 1'b1;
      hold_q      <= {HOLD_W{1'b0}};
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      hold_q      <= hold_d;
      p0_rvalid_q <= p0_rvalid_d;
      p1_rvalid_q <= p1_rvalid_d;
    end
  end

endmodule
